mem_stage: RTL and testbench

Memory-access stage of the ASIP pipeline, between execute and write back. Accepts one operation per handshake from execute, performs data-memory loads and stores over a request/acknowledge bus tolerant of variable latency, and drives the registered MEM/WB values consumed by the write-back stage: `wd_selector`, `read_data`, `alu_result`, plus register-write control. Stalls execute while a memory access is outstanding, and reports timeouts and misaligned addresses.

---
 rtl/mem_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: hands operations from execute to write-back, performing
// data-memory loads/stores over a req/ack bus with a bounded wait.
module mem_stage #(
    parameter int N       = 32,
    parameter int R       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid,
    output logic         ex_ready,
    input  logic [N-1:0] alu_result_in,
    input  logic [N-1:0] store_data,
    input  logic         mem_read_in,
    input  logic         mem_write_in,
    input  logic         wd_selector_in,
    input  logic         reg_write_in,
    input  logic [R-1:0] rd_in,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         wb_valid,
    output logic         wd_selector,
    output logic [N-1:0] read_data,
    output logic [N-1:0] alu_result,
    output logic [R-1:0] rd,
    output logic         reg_write,
    output logic         mem_error
);
    localparam int CW = 8;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [N-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic           wb_valid_q, wb_valid_d, reg_write_q, reg_write_d;
    logic           wd_selector_q, wd_selector_d, mem_error_q, mem_error_d;
    logic [N-1:0]   read_data_q, read_data_d, alu_result_q, alu_result_d;
    logic [R-1:0]   rd_q, rd_d;
    // operation held while the bus access is outstanding
    logic [N-1:0]   cap_alu_q, cap_alu_d;
    logic [R-1:0]   cap_rd_q, cap_rd_d;
    logic           cap_wsel_q, cap_wsel_d, cap_rw_q, cap_rw_d, cap_load_q, cap_load_d;

    logic is_mem, both, aligned;

    assign is_mem  = mem_read_in | mem_write_in;
    assign both    = mem_read_in & mem_write_in;
    assign aligned = (alu_result_in[1:0] == 2'b00);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        reg_write_d   = 1'b0;
        wd_selector_d = wd_selector_q;
        read_data_d   = read_data_q;
        alu_result_d  = alu_result_q;
        rd_d          = rd_q;
        mem_error_d   = mem_error_q;
        cap_alu_d     = cap_alu_q;
        cap_rd_d      = cap_rd_q;
        cap_wsel_d    = cap_wsel_q;
        cap_rw_d      = cap_rw_q;
        cap_load_d    = cap_load_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem && aligned) begin
                        // read+write together is executed as a store that never writes back
                        cap_alu_d   = alu_result_in;
                        cap_rd_d    = rd_in;
                        cap_wsel_d  = wd_selector_in;
                        cap_rw_d    = reg_write_in & ~both;
                        cap_load_d  = mem_read_in & ~mem_write_in;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write_in;
                        mem_addr_d  = {2'b00, alu_result_in[N-1:2]};
                        mem_wdata_d = store_data;
                        cnt_d       = '0;
                        state_d     = ACCESS;
                        if (both) mem_error_d = 1'b1;
                    end else begin
                        wb_valid_d    = 1'b1;
                        reg_write_d   = reg_write_in & ~is_mem;
                        wd_selector_d = wd_selector_in;
                        read_data_d   = '0;
                        alu_result_d  = alu_result_in;
                        rd_d          = rd_in;
                        if (is_mem) mem_error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_req_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    wd_selector_d = cap_wsel_q;
                    alu_result_d  = cap_alu_q;
                    rd_d          = cap_rd_q;
                    state_d       = IDLE;
                    if (mem_ack) begin
                        reg_write_d = cap_rw_q;
                        read_data_d = cap_load_q ? mem_rdata : '0;
                    end else begin
                        reg_write_d = 1'b0;
                        read_data_d = '0;
                        mem_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            wd_selector_q <= 1'b0;
            read_data_q   <= '0;
            alu_result_q  <= '0;
            rd_q          <= '0;
            mem_error_q   <= 1'b0;
            cap_alu_q     <= '0;
            cap_rd_q      <= '0;
            cap_wsel_q    <= 1'b0;
            cap_rw_q      <= 1'b0;
            cap_load_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            reg_write_q   <= reg_write_d;
            wd_selector_q <= wd_selector_d;
            read_data_q   <= read_data_d;
            alu_result_q  <= alu_result_d;
            rd_q          <= rd_d;
            mem_error_q   <= mem_error_d;
            cap_alu_q     <= cap_alu_d;
            cap_rd_q      <= cap_rd_d;
            cap_wsel_q    <= cap_wsel_d;
            cap_rw_q      <= cap_rw_d;
            cap_load_q    <= cap_load_d;
        end
    end

    assign ex_ready    = (state_q == IDLE);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign reg_write   = reg_write_q;
    assign wd_selector = wd_selector_q;
    assign read_data   = read_data_q;
    assign alu_result  = alu_result_q;
    assign rd          = rd_q;
    assign mem_error   = mem_error_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: retirements are checked against a scoreboard
// queue filled when each operation is issued.
module tb_mem_stage;
    localparam int N = 32;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_valid, ex_ready;
    logic [N-1:0] alu_result_in, store_data;
    logic         mem_read_in, mem_write_in, wd_selector_in, reg_write_in;
    logic [R-1:0] rd_in;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_ack;
    logic         wb_valid, wd_selector, reg_write, mem_error;
    logic [N-1:0] read_data, alu_result;
    logic [R-1:0] rd;

    typedef struct packed {
        logic [N-1:0] alu;
        logic [R-1:0] rd;
        logic [N-1:0] rdata;
        logic         wsel;
        logic         rw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage #(.N(N), .R(R), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result_in(alu_result_in), .store_data(store_data),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wd_selector_in(wd_selector_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wd_selector(wd_selector), .read_data(read_data), .alu_result(alu_result),
        .rd(rd), .reg_write(reg_write), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single edge; the stage must be ready.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] sd, input logic rdn,
                        input logic wrn, input logic ws, input logic rw, input logic [R-1:0] r);
        ex_valid = 1'b1; alu_result_in = a; store_data = sd; mem_read_in = rdn;
        mem_write_in = wrn; wd_selector_in = ws; reg_write_in = rw; rd_in = r;
        chk("ex_ready_at_send", N'(ex_ready), N'(1));
        step();
        ex_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    // Retirement monitor on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_retire: observed wb_valid 1 expected 0 (alu_result %h)", alu_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (alu_result === e.alu && rd === e.rd && read_data === e.rdata &&
                        wd_selector === e.wsel && reg_write === e.rw) else begin
                    errors++;
                    $error("FAIL retire: observed alu %h rd %h rdata %h wsel %b rw %b expected alu %h rd %h rdata %h wsel %b rw %b",
                           alu_result, rd, read_data, wd_selector, reg_write, e.alu, e.rd, e.rdata, e.wsel, e.rw);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; ex_valid = 1'b0; alu_result_in = '0; store_data = '0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; wd_selector_in = 1'b0;
        reg_write_in = 1'b0; rd_in = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        chk("rst_mem_req", N'(mem_req), N'(0));
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_wb_valid", N'(wb_valid), N'(0));
        chk("rst_reg_write", N'(reg_write), N'(0));
        chk("rst_read_data", read_data, '0);
        chk("rst_alu_result", alu_result, '0);
        chk("rst_mem_error", N'(mem_error), N'(0));
        chk("rst_ex_ready", N'(ex_ready), N'(1));
        rst = 1'b0;
        step();

        // non-memory op, then back-to-back second one
        sb.push_back('{alu: 32'h12, rd: 4'd3, rdata: '0, wsel: 1'b0, rw: 1'b1});
        sb.push_back('{alu: 32'h99, rd: 4'd1, rdata: '0, wsel: 1'b0, rw: 1'b0});
        send(32'h12, '0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        chk("alu_wb_valid", N'(wb_valid), N'(1));
        chk("alu_mem_req", N'(mem_req), N'(0));
        send(32'h99, '0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        step();
        chk("idle_wb_valid", N'(wb_valid), N'(0));
        chk("hold_alu_result", alu_result, 32'h99);

        // load from 0x40, ack sampled on the third ACCESS cycle
        sb.push_back('{alu: 32'h40, rd: 4'd5, rdata: 32'hDEADBEEF, wsel: 1'b1, rw: 1'b1});
        send(32'h40, '0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        chk("ld_mem_req", N'(mem_req), N'(1));
        chk("ld_mem_we", N'(mem_we), N'(0));
        chk("ld_mem_addr", mem_addr, 32'h10);
        chk("ld_busy1", N'(ex_ready), N'(0));
        step();
        chk("ld_busy2", N'(ex_ready), N'(0));
        step();
        chk("ld_busy3", N'(ex_ready), N'(0));
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("ld_req_drop", N'(mem_req), N'(0));
        chk("ld_wb_valid", N'(wb_valid), N'(1));
        chk("ld_ready_back", N'(ex_ready), N'(1));

        // store 0xCAFE to 0x8, ack in the first ACCESS cycle
        sb.push_back('{alu: 32'h8, rd: 4'd2, rdata: '0, wsel: 1'b0, rw: 1'b0});
        send(32'h8, 32'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        chk("st_mem_we", N'(mem_we), N'(1));
        chk("st_mem_wdata", mem_wdata, 32'hCAFE);
        chk("st_mem_addr", mem_addr, 32'h2);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_wb_valid", N'(wb_valid), N'(1));
        chk("st_no_error", N'(mem_error), N'(0));

        // misaligned load
        sb.push_back('{alu: 32'h41, rd: 4'd4, rdata: '0, wsel: 1'b1, rw: 1'b0});
        send(32'h41, '0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
        chk("mis_mem_req", N'(mem_req), N'(0));
        chk("mis_wb_valid", N'(wb_valid), N'(1));
        chk("mis_error", N'(mem_error), N'(1));

        // ack arriving in the last allowed cycle still succeeds
        sb.push_back('{alu: 32'h30, rd: 4'd8, rdata: 32'h55, wsel: 1'b1, rw: 1'b1});
        send(32'h30, '0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
        step(); step(); step();
        chk("edge_req_still", N'(mem_req), N'(1));
        mem_ack = 1'b1; mem_rdata = 32'h55;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("edge_wb_valid", N'(wb_valid), N'(1));

        // unacked load times out after exactly 4 request cycles
        sb.push_back('{alu: 32'h20, rd: 4'd6, rdata: '0, wsel: 1'b1, rw: 1'b0});
        send(32'h20, '0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
        n = 0;
        while (mem_req === 1'b1 && n < 10) begin
            n++;
            step();
        end
        chk("to_req_cycles", N'(n), N'(4));
        chk("to_wb_valid", N'(wb_valid), N'(1));
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_ack = 1'b0;
        chk("late_ack_req", N'(mem_req), N'(0));
        chk("late_ack_ready", N'(ex_ready), N'(1));
        chk("to_error_sticky", N'(mem_error), N'(1));

        // reset two cycles into ACCESS: nothing retires
        send(32'h44, '0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
        step();
        chk("rr_req_before", N'(mem_req), N'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_mem_req", N'(mem_req), N'(0));
        chk("rr_ex_ready", N'(ex_ready), N'(1));
        chk("rr_error_clr", N'(mem_error), N'(0));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rr_no_wb", N'(wb_valid), N'(0));

        // read and write together: executed as a store, flagged, no register write
        sb.push_back('{alu: 32'h10, rd: 4'd7, rdata: '0, wsel: 1'b0, rw: 1'b0});
        send(32'h10, 32'h77, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
        chk("both_mem_we", N'(mem_we), N'(1));
        chk("both_error", N'(mem_error), N'(1));
        mem_rdata = 32'hFFFF_FFFF; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("both_wb_valid", N'(wb_valid), N'(1));

        step(); step();
        chk("sb_drained", N'(sb.size()), N'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
